payment_collector: RTL and testbench
====================================

Name: payment_collector

Overview:
Upstream stage of the change maker. Accumulates inserted coins into a credit register and accepts a product selection. Hands {choice, payment} to the change maker through a valid/ready handshake once credit covers the price. Cancel or inactivity timeout returns the credit as a refund.

Parameters:
MAX_CREDIT, 15, highest credit held; a coin that would exceed it is rejected (must be 4..15).
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before automatic refund (must be >= 1).
TIMER_W, 10, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  reset, synchronous, active-high.
coin_valid  in  1  one-cycle strobe: coin inserted.
coin_value  in  2  coin worth in units (1..3); 0 is ignored and neither accepted nor rejected.
select_valid  in  1  one-cycle strobe: product selected.
select_choice  in  2  00 granola = 4, 01 chips = 3, 10 candy = 2, 11 gum = 1 units.
cancel  in  1  one-cycle strobe: refund request.
vend_ready  in  1  downstream accepts the vend transaction.
vend_valid  out  1  transaction pending; held until accepted.
choice  out  2  latched selection; stable while vend_valid.
payment  out  4  latched credit at selection; stable while vend_valid.
credit  out  4  current accumulated credit.
coin_reject  out  1  one-cycle pulse: coin refused.
insufficient  out  1  one-cycle pulse: selection refused because credit < price.
refund_valid  out  1  one-cycle pulse: refund issued.
refund_amount  out  4  refund value; valid only with refund_valid, 0 otherwise.
busy  out  1  high in VEND and REFUND.

Behaviour:
- All outputs are registered. Reset forces state IDLE and drives every output to 0, including credit and the timer. Reset mid-VEND drops vend_valid the next cycle without a handshake, and the credit is lost.
- State IDLE (credit = 0):
  - A coin with value 1..3 loads credit = value and moves to COLLECT.
  - A select pulses insufficient.
  - cancel is ignored.
- State COLLECT (credit > 0). Priority when strobes coincide: cancel > select > coin. The lower-priority strobe in the same cycle is dropped silently; no reject pulse is raised for it.
  - cancel: refund_amount = credit, go to REFUND.
  - select with credit >= price: choice <= select_choice, payment <= credit, vend_valid <= 1, go to VEND.
  - select with credit < price: insufficient pulse, stay in COLLECT, credit unchanged.
  - coin where credit + value <= MAX_CREDIT: credit += value. The sum is computed 5 bits wide, with no wrap.
  - coin where credit + value > MAX_CREDIT: coin_reject pulse, credit unchanged.
  - Timer: reset to 0 on any coin, select or cancel strobe, otherwise incremented. When it reaches TIMEOUT_CYCLES-1, refund_amount = credit and go to REFUND.
- State VEND:
  - vend_valid, choice and payment are held.
  - Every coin is rejected (coin_reject pulse). select and cancel are ignored.
  - On a cycle with vend_valid && vend_ready: vend_valid <= 0, credit <= 0, go to IDLE.
  - If vend_ready is already high when VEND is entered, the transfer completes in the first VEND cycle.
- State REFUND:
  - Lasts exactly 1 cycle: refund_valid = 1 with refund_amount, then credit <= 0, refund_amount <= 0, go to IDLE.
  - A coin arriving in this cycle is rejected.
- Latency:
  - A strobe sampled at edge N is reflected in the outputs after edge N (visible in cycle N+1).
  - Select to vend_valid takes 1 cycle.
  - Cancel to refund_valid takes 1 cycle.
- Invariants:
  - payment >= price(choice) whenever vend_valid = 1, so the change maker never sees negative change.
  - credit <= MAX_CREDIT at all times.

Optional Feature:
PAYMENT_COLLECTOR_SALES_COUNT_EN
- Defined: adds output sales_count [7:0]. It is cleared by reset and incremented on each completed vend handshake. It saturates at 255 and never wraps. Refunds do not count.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Coins 2, 2, then select 00, vend_ready = 1 -> credit 2 then 4; vend_valid high 1 cycle after select with choice 00 and payment 4; credit 0 after the handshake.
- Coin 1, select 01 -> insufficient pulses once, credit stays 1; then coin 3 and select 01 -> vend with payment 4.
- Coins 3 ×5 (credit 15), then coin 1 -> coin_reject pulse, credit stays 15; cancel -> refund_valid for 1 cycle, refund_amount 15, then IDLE with credit 0.
- Coin 2 with TIMEOUT_CYCLES = 8 and no further strobes -> refund_valid with amount 2 on the 8th cycle after the coin; a coin at cycle 5 restarts the count.
- vend_ready held low for 10 cycles in VEND with coins inserted -> vend_valid, choice and payment stay stable, each coin pulses coin_reject; vend_ready = 1 -> handshake completes and state returns to IDLE. Repeat with reset asserted mid-VEND -> all outputs 0 the next cycle.
- Select and cancel in the same cycle at credit 4 -> refund of 4 and no vend; with the macro defined, 3 successful vends -> sales_count = 3.

Source files
------------

// File: rtl/payment_collector.sv
// payment_collector: upstream stage of the change maker.
// Accumulates coins into a credit register, accepts a product selection and
// hands {choice, payment} downstream over a valid/ready handshake once the
// credit covers the price. Cancel or an idle timeout refunds the credit.
// All outputs are registered; reset is synchronous and active-high.
//
// Optional build macro: PAYMENT_COLLECTOR_SALES_COUNT_EN adds the saturating
// sales_count output, bumped on every completed vend handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no credit held; first valid coin starts a collection
// COLLECT | credit > 0; coins, select, cancel and idle timeout handled
// VEND    | vend transaction offered downstream, waiting for vend_ready
// REFUND  | single cycle presenting refund_valid / refund_amount
module payment_collector #(
    parameter int MAX_CREDIT     = 15,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] select_choice,
    input  logic       cancel,
    input  logic       vend_ready,
    output logic       vend_valid,
    output logic [1:0] choice,
    output logic [3:0] payment,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       refund_valid,
    output logic [3:0] refund_amount,
    output logic       busy
`ifdef PAYMENT_COLLECTOR_SALES_COUNT_EN
    ,
    output logic [7:0] sales_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    // Idle timer is a down-counter: reloaded on any strobe, refund fires
    // when it has sat at zero for a strobe-free COLLECT cycle.
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]         MAX_SUM    = 5'(MAX_CREDIT);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         credit_d, payment_d, refund_amount_d;
    logic [1:0]         choice_d;
    logic               vend_valid_d, coin_reject_d, insufficient_d;
    logic               refund_valid_d, busy_d;

    logic               coin_ok, any_strobe, timer_done, price_met, sum_fits;
    logic [4:0]         coin_sum;
    logic [3:0]         price;

    function automatic logic [3:0] price_of(input logic [1:0] sel);
        logic [3:0] p;
        case (sel)
            2'b00:   p = 4'd4;
            2'b01:   p = 4'd3;
            2'b10:   p = 4'd2;
            default: p = 4'd1;
        endcase
        return p;
    endfunction

    // A zero-valued coin strobe is treated as no coin at all.
    assign coin_ok    = coin_valid && (coin_value != 2'd0);
    assign any_strobe = coin_ok || select_valid || cancel;
    assign timer_done = (timer_q == '0);
    assign price      = price_of(select_choice);
    assign price_met  = (credit >= price);
    assign coin_sum   = {1'b0, credit} + {3'b000, coin_value};
    assign sum_fits   = (coin_sum <= MAX_SUM);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in COLLECT cancel outranks select, select outranks coin.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (coin_ok) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (cancel)
                    state_d = ST_REFUND;
                else if (select_valid && price_met)
                    state_d = ST_VEND;
                else if (!any_strobe && timer_done)
                    state_d = ST_REFUND;
            end
            ST_VEND: begin
                if (vend_valid && vend_ready) state_d = ST_IDLE;
            end
            ST_REFUND: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        credit_d        = credit;
        timer_d         = timer_q;
        choice_d        = choice;
        payment_d       = payment;
        vend_valid_d    = vend_valid;
        coin_reject_d   = 1'b0;
        insufficient_d  = 1'b0;
        refund_valid_d  = 1'b0;
        refund_amount_d = 4'd0;
        busy_d          = (state_d == ST_VEND) || (state_d == ST_REFUND);
        case (state_q)
            ST_IDLE: begin
                if (select_valid) insufficient_d = 1'b1;
                if (coin_ok) begin
                    credit_d = {2'b00, coin_value};
                    timer_d  = TIMER_LOAD;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    refund_valid_d  = 1'b1;
                    refund_amount_d = credit;
                end else if (select_valid) begin
                    if (price_met) begin
                        choice_d     = select_choice;
                        payment_d    = credit;
                        vend_valid_d = 1'b1;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (coin_ok) begin
                    if (sum_fits)
                        credit_d = coin_sum[3:0];
                    else
                        coin_reject_d = 1'b1;
                end
                if (any_strobe) begin
                    timer_d = TIMER_LOAD;
                end else if (timer_done) begin
                    refund_valid_d  = 1'b1;
                    refund_amount_d = credit;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_VEND: begin
                if (coin_ok) coin_reject_d = 1'b1;
                if (vend_valid && vend_ready) begin
                    vend_valid_d = 1'b0;
                    credit_d     = 4'd0;
                end
            end
            ST_REFUND: begin
                if (coin_ok) coin_reject_d = 1'b1;
                credit_d = 4'd0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset clears everything, including a pending vend.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q       <= '0;
            credit        <= 4'd0;
            choice        <= 2'd0;
            payment       <= 4'd0;
            vend_valid    <= 1'b0;
            coin_reject   <= 1'b0;
            insufficient  <= 1'b0;
            refund_valid  <= 1'b0;
            refund_amount <= 4'd0;
            busy          <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            credit        <= credit_d;
            choice        <= choice_d;
            payment       <= payment_d;
            vend_valid    <= vend_valid_d;
            coin_reject   <= coin_reject_d;
            insufficient  <= insufficient_d;
            refund_valid  <= refund_valid_d;
            refund_amount <= refund_amount_d;
            busy          <= busy_d;
        end
    end

`ifdef PAYMENT_COLLECTOR_SALES_COUNT_EN
    // Completed vend handshakes, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset)
            sales_count <= 8'd0;
        else if (state_q == ST_VEND && vend_valid && vend_ready && sales_count != 8'hFF)
            sales_count <= sales_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_payment_collector.sv
// Scoreboard bench for payment_collector: the driver feeds directed and
// random strobes, a rule-level model pushes expected outputs into queues
// tagged with the cycle they must appear in, and a monitor checks them.
module tb_payment_collector;

    localparam int MAXC = 15;
    localparam int TO   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_value = 2'd0;
    logic       select_valid = 1'b0;
    logic [1:0] select_choice = 2'd0;
    logic       cancel = 1'b0;
    logic       vend_ready = 1'b0;
    logic       vend_valid;
    logic [1:0] choice;
    logic [3:0] payment;
    logic [3:0] credit;
    logic       coin_reject;
    logic       insufficient;
    logic       refund_valid;
    logic [3:0] refund_amount;
    logic       busy;
`ifdef PAYMENT_COLLECTOR_SALES_COUNT_EN
    logic [7:0] sales_count;
`endif

    payment_collector #(.MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TO), .TIMER_W(10)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .select_valid(select_valid), .select_choice(select_choice),
        .cancel(cancel), .vend_ready(vend_ready),
        .vend_valid(vend_valid), .choice(choice), .payment(payment),
        .credit(credit), .coin_reject(coin_reject), .insufficient(insufficient),
        .refund_valid(refund_valid), .refund_amount(refund_amount), .busy(busy)
`ifdef PAYMENT_COLLECTOR_SALES_COUNT_EN
        , .sales_count(sales_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int credit;
        int vend_valid;
        int busy;
        int coin_reject;
        int insufficient;
        int refund_valid;
        int choice;
        int payment;
        int sales;
    } snap_t;

    typedef struct {
        int cyc;
        int a;
        int b;
    } evt_t;

    snap_t sq[$];
    evt_t  vq[$];
    evt_t  rq[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the machine is doing, in plain terms.
    localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_REFUND = 3;
    int m_mode = M_IDLE;
    int m_credit = 0;
    int m_idle = 0;
    int m_choice = 0;
    int m_pay = 0;
    int m_sales = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit cv, input int cval, input bit sv,
                              input int sch, input bit cn, input bit rdy);
        snap_t s;
        evt_t  e;
        int    nxt = cyc + 1;
        bit    coin = cv && (cval != 0);
        s = '{default: 0};
        s.cyc = nxt;
        if (rst) begin
            m_mode = M_IDLE; m_credit = 0; m_idle = 0;
            m_choice = 0; m_pay = 0; m_sales = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (sv) s.insufficient = 1;
                    if (coin) begin
                        m_credit = cval; m_mode = M_COLLECT; m_idle = 0;
                    end
                end
                M_COLLECT: begin
                    if (cn) begin
                        e.cyc = nxt; e.a = m_credit; e.b = 0; rq.push_back(e);
                        s.refund_valid = 1; m_mode = M_REFUND;
                    end else if (sv) begin
                        if (m_credit >= 4 - sch) begin
                            m_choice = sch; m_pay = m_credit; m_mode = M_VEND;
                        end else begin
                            s.insufficient = 1;
                        end
                    end else if (coin) begin
                        if (m_credit + cval <= MAXC) m_credit = m_credit + cval;
                        else s.coin_reject = 1;
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin
                            e.cyc = nxt; e.a = m_credit; e.b = 0; rq.push_back(e);
                            s.refund_valid = 1; m_mode = M_REFUND;
                        end
                    end
                    if (cn || sv || coin) m_idle = 0;
                end
                M_VEND: begin
                    if (coin) s.coin_reject = 1;
                    if (rdy) begin
                        e.cyc = cyc; e.a = m_choice; e.b = m_pay; vq.push_back(e);
                        m_credit = 0; m_mode = M_IDLE;
                        if (m_sales < 255) m_sales++;
                    end
                end
                default: begin
                    if (coin) s.coin_reject = 1;
                    m_credit = 0; m_mode = M_IDLE;
                end
            endcase
        end
        s.credit     = m_credit;
        s.vend_valid = (m_mode == M_VEND);
        s.busy       = (m_mode == M_VEND) || (m_mode == M_REFUND);
        s.choice     = m_choice;
        s.payment    = m_pay;
        s.sales      = m_sales;
        sq.push_back(s);
    endtask

    task automatic drive(input bit rst, input bit cv, input int cval, input bit sv,
                         input int sch, input bit cn, input bit rdy);
        @(posedge clk);
        #2;
        reset = rst;
        coin_valid = cv;
        coin_value = 2'(cval);
        select_valid = sv;
        select_choice = 2'(sch);
        cancel = cn;
        vend_ready = rdy;
        model_step(rst, cv, cval, sv, sch, cn, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic coin(input int v);
        drive(0, 1, v, 0, 0, 0, 0);
    endtask

    task automatic sel(input int c, input bit rdy);
        drive(0, 0, 0, 1, c, 0, rdy);
    endtask

    // Monitor: per-cycle output snapshot plus handshake and refund events.
    initial begin
        snap_t s;
        evt_t  e;
        int    hs, exp_hs;
        forever begin
            @(negedge clk);
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                s = sq.pop_front();
                chk("snapshot_stale", s.cyc, cyc);
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("credit", int'(credit), s.credit);
                chk("vend_valid", int'(vend_valid), s.vend_valid);
                chk("busy", int'(busy), s.busy);
                chk("coin_reject", int'(coin_reject), s.coin_reject);
                chk("insufficient", int'(insufficient), s.insufficient);
                chk("refund_valid", int'(refund_valid), s.refund_valid);
                if (s.vend_valid != 0) begin
                    chk("choice_held", int'(choice), s.choice);
                    chk("payment_held", int'(payment), s.payment);
                end
                if (s.refund_valid == 0)
                    chk("refund_amount_quiet", int'(refund_amount), 0);
`ifdef PAYMENT_COLLECTOR_SALES_COUNT_EN
                chk("sales_count", int'(sales_count), s.sales);
`endif
            end
            hs = (vend_valid === 1'b1 && vend_ready && !reset) ? 1 : 0;
            exp_hs = (vq.size() > 0 && vq[0].cyc == cyc) ? 1 : 0;
            if (hs != 0 || exp_hs != 0) begin
                chk("vend_handshake", hs, exp_hs);
                if (exp_hs != 0) begin
                    e = vq.pop_front();
                    if (hs != 0) begin
                        chk("vend_choice", int'(choice), e.a);
                        chk("vend_payment", int'(payment), e.b);
                    end
                end
            end
            hs = (refund_valid === 1'b1) ? 1 : 0;
            exp_hs = (rq.size() > 0 && rq[0].cyc == cyc) ? 1 : 0;
            if (hs != 0 || exp_hs != 0) begin
                chk("refund_event", hs, exp_hs);
                if (exp_hs != 0) begin
                    e = rq.pop_front();
                    if (hs != 0) chk("refund_amount", int'(refund_amount), e.a);
                end
            end
        end
    end

    initial begin
        int r, lim_c, lim_s, lim_x;
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);

        // two coins of 2, buy granola with downstream ready
        coin(2); coin(2); sel(0, 1); idle(3, 1);

        // insufficient, then top up and buy chips
        coin(1); sel(1, 0); coin(3); sel(1, 1); idle(2, 1);

        // fill to MAX, overflow coin rejected, cancel refunds 15
        repeat (5) coin(3);
        coin(1);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(2, 0);

        // timeout, then timeout restarted by a coin
        coin(2); idle(TO + 3, 0);
        coin(2); idle(4, 0); coin(1); idle(TO + 3, 0);

        // stalled vend with coins hammering it, then release
        coin(3); coin(2); sel(0, 0);
        repeat (10) drive(0, 1, 1 + $urandom_range(0, 2), 0, 0, 0, 0);
        idle(1, 1); idle(2, 0);

        // reset while a vend is pending
        coin(3); coin(1); sel(2, 0); idle(3, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        idle(2, 0);

        // select and cancel together: cancel wins
        coin(3); coin(1);
        drive(0, 0, 0, 1, 0, 1, 1);
        idle(2, 1);

        // three cheap vends
        repeat (3) begin
            coin(1); sel(3, 1); idle(2, 1);
        end

        // random traffic, busy then sparse
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin lim_c = 30; lim_s = 10; lim_x = 3; end
            else          begin lim_c = 10; lim_s = 4;  lim_x = 1; end
            r = $urandom_range(0, 199);
            drive(r == 0,
                  $urandom_range(0, 99) < lim_c, $urandom_range(0, 3),
                  $urandom_range(0, 99) < lim_s, $urandom_range(0, 3),
                  $urandom_range(0, 99) < lim_x,
                  $urandom_range(0, 99) < 50);
        end

        idle(3, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("leftover_snapshots", sq.size(), 0);
        chk("leftover_vends", vq.size(), 0);
        chk("leftover_refunds", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
